// File: rtl/seq_shift_unit_pkg.sv
// Shared definitions for the sequential shift unit.
//   op_t     : 2-bit shift-mode encoding (LLS/LRS/ARS/ROL)
//   S_*      : FSM state encodings (kept as plain constants for legacy tools)
package shift_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_LLS = 2'b00;  // logical left
  localparam op_t OP_LRS = 2'b01;  // logical right
  localparam op_t OP_ARS = 2'b10;  // arithmetic right
  localparam op_t OP_ROL = 2'b11;  // rotate left

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Command/result bundle of the shift unit.
//   in_valid/in_ready   : command handshake, carries A, shamt, op
//   out_valid/out_ready : result handshake, carries Y, OF
//   slave  : the shift unit side
//   master : the producer/consumer side
interface seq_shift_unit_if
  import shift_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [SHAMT_W-1:0] shamt;
  op_t                op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   Y;
  logic               OF;

  modport slave (
    input  in_valid, A, shamt, op, out_ready,
    output in_ready, out_valid, Y, OF
  );

  modport master (
    output in_valid, A, shamt, op, out_ready,
    input  in_ready, out_valid, Y, OF
  );
endinterface

// File: rtl/seq_shift_unit_step.sv
// One-bit shift step, purely combinational.
//   y_i     : current value
//   op_i    : shift mode
//   y_o     : value after one step
//   bit_o   : bit that leaves the word (MSB for left modes, LSB for right)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] y_i,
  input  op_t              op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             bit_o
);
  always_comb begin
    y_o   = y_i;
    bit_o = 1'b0;
    case (op_i)
      OP_LLS: begin y_o = {y_i[WIDTH-2:0], 1'b0};         bit_o = y_i[WIDTH-1]; end
      OP_LRS: begin y_o = {1'b0, y_i[WIDTH-1:1]};         bit_o = y_i[0];       end
      OP_ARS: begin y_o = {y_i[WIDTH-1], y_i[WIDTH-1:1]}; bit_o = y_i[0];       end
      default: begin y_o = {y_i[WIDTH-2:0], y_i[WIDTH-1]}; bit_o = y_i[WIDTH-1]; end
    endcase
  end
endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: one bit position per clock behind valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command (A, shamt, op) in, result (Y, OF) out
// Command accepted in IDLE, SHIFT runs shamt steps, DONE presents the
// result until the consumer takes it. OF collects bits lost by LLS only.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_shift_unit_if.slave  bus
);
  localparam logic [SHAMT_W-1:0] MAX_SH = SHAMT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               of_q, of_d;
  op_t                op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [SHAMT_W-1:0] sh_sat;
  logic [WIDTH-1:0]   y_step;
  logic               bit_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .y_i   (y_q),
    .op_i  (op_q),
    .y_o   (y_step),
    .bit_o (bit_out)
  );

  // Only reachable when WIDTH is not a power of two.
  assign sh_sat = (bus.shamt > MAX_SH) ? MAX_SH : bus.shamt;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    of_d    = of_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          y_d     = bus.A;
          op_d    = bus.op;
          of_d    = 1'b0;
          cnt_d   = sh_sat;
          state_d = (sh_sat == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        y_d   = y_step;
        of_d  = of_q | ((op_q == OP_LLS) & bit_out);
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      of_q    <= 1'b0;
      op_q    <= OP_LLS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      of_q    <= of_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.Y         = y_q;
  assign bus.OF        = of_q;
endmodule

// File: tb/tb_seq_shift_unit.sv
module tb_seq_shift_unit;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_shift_unit_if #(.WIDTH(16), .SHAMT_W(4)) bus();

  seq_shift_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    op_t         op;
    logic [15:0] a;
    logic [3:0]  sh;
    logic [15:0] y;
    logic        of;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drop in_valid, wait for the result, check it, then check the one-cycle pulse.
  task automatic collect(input string name, input int exp_lat,
                         input logic [15:0] ey, input logic eof);
    int cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, cyc, exp_lat);
    chk({name, " Y"}, bus.Y, ey);
    chk({name, " OF"}, bus.OF, eof);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({name, " pulse"}, bus.out_valid, 1'b0);
  endtask

  task automatic issue(input string name, input op_t op, input logic [15:0] a, input logic [3:0] sh);
    @(negedge clk);
    chk({name, " in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.A        = a;
    bus.shamt    = sh;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = OP_LLS;
    bus.A         = '0;
    bus.shamt     = '0;
    bus.out_ready = 1'b1;

    tbl[0]  = '{OP_LLS, 16'h0001, 4'd4,  16'h0010, 1'b0};
    tbl[1]  = '{OP_LLS, 16'h8001, 4'd1,  16'h0002, 1'b1};
    tbl[2]  = '{OP_LLS, 16'h4000, 4'd1,  16'h8000, 1'b0};
    tbl[3]  = '{OP_ARS, 16'h8000, 4'd15, 16'hFFFF, 1'b0};
    tbl[4]  = '{OP_LRS, 16'h8000, 4'd15, 16'h0001, 1'b0};
    tbl[5]  = '{OP_ROL, 16'h8001, 4'd1,  16'h0003, 1'b0};
    tbl[6]  = '{OP_LLS, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0};
    tbl[7]  = '{OP_ROL, 16'h1234, 4'd4,  16'h2341, 1'b0};
    tbl[8]  = '{OP_ARS, 16'h7000, 4'd3,  16'h0E00, 1'b0};
    tbl[9]  = '{OP_LLS, 16'h00FF, 4'd12, 16'hF000, 1'b1};
    tbl[10] = '{OP_LRS, 16'hF0F0, 4'd4,  16'h0F0F, 1'b0};

    #12;
    chk("reset Y", bus.Y, 16'h0000);
    chk("reset OF", bus.OF, 1'b0);
    chk("reset in_ready", bus.in_ready, 1'b1);
    chk("reset out_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(nm, tbl[i].op, tbl[i].a, tbl[i].sh);
      collect(nm, int'(tbl[i].sh) + 1, tbl[i].y, tbl[i].of);
    end

    // Backpressure: result held while out_ready low, next command waits.
    bus.out_ready = 1'b0;
    issue("bp", OP_LLS, 16'h0003, 4'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = OP_ROL;
    bus.A        = 16'h0001;
    bus.shamt    = 4'd1;
    for (int i = 0; i < 3; i++) begin
      chk("bp out_valid", bus.out_valid, 1'b1);
      chk("bp Y", bus.Y, 16'h000C);
      chk("bp OF", bus.OF, 1'b0);
      chk("bp in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", bus.out_valid, 1'b0);
    chk("bp release in_ready", bus.in_ready, 1'b1);
    collect("bp pending", 2, 16'h0002, 1'b0);

    // Asynchronous reset after three LLS steps.
    issue("rst", OP_LLS, 16'hFFFF, 4'd8);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst pre Y", bus.Y, 16'hFFF8);
    chk("rst pre OF", bus.OF, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst Y", bus.Y, 16'h0000);
    chk("rst OF", bus.OF, 1'b0);
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        seen |= bus.out_valid;
      end
      chk("rst no result", seen, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
